// File: rtl/reg_fifo_pkg.sv
// Shared constants and helpers for the reg_fifo_unit elastic buffer.
package reg_fifo_pkg;

    localparam int MODE_FIFO  = 0;
    localparam int MODE_DELAY = 1;

    // Explicit wrap so that depths which are not a power of two index correctly.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/reg_fifo_store.sv
// DEPTH x WIDTH register storage: one write port, one combinational read port, async clear.
module reg_fifo_store
    import reg_fifo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_fifo_unit.sv
// CGRA fabric elastic buffer: handshaked FIFO (MODE=0) or fixed-latency delay line (MODE=1).
module reg_fifo_unit
    import reg_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int MODE       = 0,
    parameter int EN_TIED    = 0,
    parameter int FLUSH_TIED = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic en_e;
    logic fl_e;
    logic unused_in;

    assign en_e = (EN_TIED != 0) ? 1'b1 : en;
    assign fl_e = (FLUSH_TIED != 0) ? 1'b0 : flush;
    // en/flush/out_ready are dead in some configurations.
    assign unused_in = ^{en, flush, out_ready};

    if (MODE == MODE_FIFO) begin : g_fifo
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] occ;
        logic             push;
        logic             pop;

        // No full pass-through: a full buffer refuses input even while draining.
        assign in_ready  = !reset && en_e && (occ != CNT_W'(DEPTH));
        assign out_valid = !reset && en_e && (occ != '0);
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;
        assign count     = occ;

        reg_fifo_store #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR_W(PTR_W)
        ) u_store (
            .clk  (clk),
            .reset(reset),
            .we   (push && !fl_e),
            .waddr(wr_ptr),
            .wdata(in_data),
            .raddr(rd_ptr),
            .rdata(out_data)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else if (fl_e) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
                if (pop)  rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
                if (push && !pop) begin
                    occ <= occ + 1'b1;
                end else if (pop && !push) begin
                    occ <= occ - 1'b1;
                end
            end
        end
    end else begin : g_delay
        logic [DEPTH-1:0] vld;
        logic [WIDTH-1:0] dat [DEPTH];

        // Flush drops the valid bits only; stale data behind an invalid stage is never presented as valid.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    dat[i] <= '0;
                end
            end else if (fl_e) begin
                vld <= '0;
            end else if (en_e) begin
                vld[0] <= in_valid;
                dat[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    vld[i] <= vld[i-1];
                    dat[i] <= dat[i-1];
                end
            end
        end

        assign in_ready  = !reset && en_e;
        assign out_valid = vld[DEPTH-1];
        assign out_data  = dat[DEPTH-1];
        assign count     = CNT_W'($countones(vld));
    end

endmodule

// File: doc/reg_fifo_unit.md
Name: reg_fifo_unit

Overview:
- Parametrised successor to the single-register fabric primitive: a WIDTH-bit, DEPTH-entry elastic buffer for the CGRA dataflow fabric with valid/ready handshakes.
- MODE selects a handshaked FIFO or a fixed-latency delay line.
- Used between ALU/compare/Mem tiles to absorb stalls or balance path latency.
- Config-time parameters are fixed per bitstream; no runtime reconfiguration.

Parameters:
- WIDTH, 32, data width in bits; at least 1.
- DEPTH, 4, number of entries / delay stages; at least 1, need not be a power of 2.
- MODE, 0, 0 = FIFO (valid/ready), 1 = delay line (fixed latency DEPTH).
- EN_TIED, 0, 1 = treat en as constant 1 (successor of tide_en).
- FLUSH_TIED, 0, 1 = treat flush as constant 0 (successor of tide_rst).

Ports:
- clk, input, 1, fabric clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- en, input, 1, clock enable; when low the block holds all state.
- flush, input, 1, synchronous clear; same effect as reset, takes effect at the next edge.
- in_data, input, WIDTH, write data.
- in_valid, input, 1, producer has data.
- in_ready, output, 1, block accepts data this cycle.
- out_data, output, WIDTH, read data.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts data (ignored when MODE=1).
- count, output, $clog2(DEPTH+1), current occupancy (MODE=0) or number of valid stages (MODE=1).

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - count=0, out_valid=0, out_data=0, in_ready=0.
  - Pointers are 0; storage is cleared to 0.
- Effective enable: en_e = EN_TIED ? 1 : en.
- Effective flush: fl_e = FLUSH_TIED ? 0 : flush.
- fl_e=1 at an edge clears pointers, count and valid bits regardless of en_e. It has priority over a push or pop in the same cycle, and the push is dropped.
- MODE=0 (FIFO):
  - in_ready = en_e and (count != DEPTH).
  - out_valid = en_e and (count != 0).
  - push = in_valid and in_ready; pop = out_valid and out_ready.
  - out_data = entry at rd_ptr, combinational from storage. It shows the head entry whenever count != 0 and holds the last value otherwise.
  - Latency: zero-bypass is not provided. Data pushed at edge N is visible on out_data/out_valid after edge N.
  - Pointers wrap DEPTH-1 -> 0 explicitly, so any DEPTH works.
  - Push and pop together: both pointers advance and count is unchanged.
  - Full: in_ready=0, even if out_ready=1 the same cycle (no full pass-through).
  - Empty: out_valid=0 and a pop cannot occur.
  - count changes by +1 on push-only, -1 on pop-only, 0 otherwise.
  - en_e=0: in_ready=0 and out_valid=0, so no transfer occurs; storage and count are held.
- MODE=1 (delay line):
  - Shift register of DEPTH stages, each holding {valid, data}.
  - in_ready = en_e; out_ready is ignored.
  - Each enabled edge: stage0 <= {in_valid, in_data} and stage i <= stage i-1.
  - out_valid/out_data = the last stage, giving a fixed latency of exactly DEPTH enabled edges.
  - en_e=0 freezes all stages.
  - count = popcount of stage valid bits.
- DEPTH=1, MODE=0: single-entry buffer. in_ready = !out_valid, so throughput is one item per 2 cycles under continuous traffic.
- Reset or flush mid-stream discards all stored items. No partial output appears afterwards.
- Arithmetic: count and pointer arithmetic are unsigned, with widths sized to avoid overflow at DEPTH.

Decomposition:
- Package reg_fifo_pkg holds:
  - MODE_FIFO=0 and MODE_DELAY=1 constants.
  - A function ptr_next(ptr, depth) implementing the explicit wrap.
- Sub-module reg_fifo_store: DEPTH x WIDTH storage with one write port and one combinational read port, with async clear.
- The FIFO control and the delay-line shift are generated in the top module by MODE.

Test Plan:
- MODE=0, DEPTH=4: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; a fifth push of 0x55 is not accepted. Then out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 in order, then out_valid=0 and count=0.
- MODE=0, DEPTH=3: continuous push/pop of incrementing values 0..9 with in_valid=out_ready=1 from count=1 -> count stays 1 and output order is preserved through pointer wrap.
- MODE=0: with count=2, assert en=0 for 3 cycles while in_valid=out_ready=1 -> no transfers, count stays 2, and data is intact afterwards.
- MODE=0: with count=3, assert flush together with in_valid=1 -> next cycle count=0 and out_valid=0. Assert reset asynchronously mid-cycle -> outputs go to 0 immediately, without waiting for a clock edge.
- MODE=1, DEPTH=3: drive in_valid/in_data = 1/0xA at edge 0 and 0/x at edges 1..3 -> out_valid=1 and out_data=0xA exactly after edge 2 (the third enabled edge, edges counted from 0), and 0 otherwise. Dropping en for one cycle delays the result by one cycle.
- DEPTH=1, MODE=0: stream 4 items with out_ready=1 -> they are accepted every other cycle and in_ready alternates 1,0.
